// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter sampling path: counter indices,
// record layout and the scan FSM state type.
package perf_pkg;

  localparam int NUM_CNT    = 9;
  localparam int FIFO_DEPTH = 16;
  localparam int DROP_W     = 16;

  localparam int SEL_W   = 4;
  localparam int SEQ_W   = 8;
  localparam int DELTA_W = 32;

  localparam logic [SEL_W-1:0] CNT_CYCLE   = 4'd0;
  localparam logic [SEL_W-1:0] CNT_INSTR   = 4'd1;
  localparam logic [SEL_W-1:0] CNT_CHIT    = 4'd2;
  localparam logic [SEL_W-1:0] CNT_CMISS   = 4'd3;
  localparam logic [SEL_W-1:0] CNT_BTAKEN  = 4'd4;
  localparam logic [SEL_W-1:0] CNT_BNTAKEN = 4'd5;
  localparam logic [SEL_W-1:0] CNT_BMISP   = 4'd6;
  localparam logic [SEL_W-1:0] CNT_STALL   = 4'd7;
  localparam logic [SEL_W-1:0] CNT_IRQ     = 4'd8;

  // Record = {seq, idx, delta}
  localparam int REC_W         = SEQ_W + SEL_W + DELTA_W;
  localparam int REC_DELTA_LSB = 0;
  localparam int REC_IDX_LSB   = REC_DELTA_LSB + DELTA_W;
  localparam int REC_SEQ_LSB   = REC_IDX_LSB + SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  function automatic logic [REC_W-1:0] pack_rec(input logic [SEQ_W-1:0]   seq,
                                                input logic [SEL_W-1:0]   idx,
                                                input logic [DELTA_W-1:0] delta);
    return {seq, idx, delta};
  endfunction

endpackage

// File: rtl/perf_sample_engine_if.sv
// Bus between the sample engine, the counter bank read port and the record consumer.
interface perf_sample_engine_if;
  import perf_pkg::*;

  logic [SEL_W-1:0]   counter_select;
  logic [DELTA_W-1:0] selected_counter;
  logic               out_valid;
  logic               out_ready;
  logic [SEQ_W-1:0]   out_seq;
  logic [SEL_W-1:0]   out_idx;
  logic [DELTA_W-1:0] out_delta;

  modport master (
    output counter_select,
    input  selected_counter,
    output out_valid,
    input  out_ready,
    output out_seq,
    output out_idx,
    output out_delta
  );

  modport slave (
    input  counter_select,
    output selected_counter,
    input  out_valid,
    output out_ready,
    input  out_seq,
    input  out_idx,
    input  out_delta
  );

endinterface

// File: rtl/perf_sample_fifo.sv
// First-word-fall-through record FIFO with occupancy output; head reads 0 when empty.
module perf_sample_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (level != '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign head    = valid ? mem[rd_ptr] : '0;

  // Storage needs no reset: the head is masked until something is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/perf_sample_engine.sv
// Periodic / on-demand scanner of the counter bank; queues per-counter deltas as records.
//  state | meaning
//  IDLE  | waiting for a timer fire or sample_req
//  SCAN  | one counter per cycle, idx 0..NUM_CNT-1, record pushed each cycle
//  DONE  | bump seq; rescan if a trigger was pending, else back to IDLE
module perf_sample_engine
  import perf_pkg::*;
#(
  parameter int NUM_CNT    = perf_pkg::NUM_CNT,
  parameter int FIFO_DEPTH = perf_pkg::FIFO_DEPTH,
  parameter int DROP_W     = perf_pkg::DROP_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [15:0]                  sample_interval,
  input  logic                         sample_req,
  input  logic                         clear_stats,
  perf_sample_engine_if.master         bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_count
);

  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   idx;
  logic               pending;
  logic [SEQ_W-1:0]   seq;
  logic [15:0]        timer;
  logic               armed;
  logic               fire;
  logic               trigger;
  logic               scanning;
  logic               last_idx;
  logic [DELTA_W-1:0] prev [NUM_CNT];
  logic [DELTA_W-1:0] cur;
  logic [DELTA_W-1:0] delta;
  logic               fifo_full;
  logic               fifo_valid;
  logic               drop;
  logic [REC_W-1:0]   head;

  // armed distinguishes "freshly enabled, load the interval" from "counted down to 0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      armed <= 1'b0;
    end else if (enable) begin
      if (sample_interval == '0) begin
        timer <= '0;
        armed <= 1'b0;
      end else if (!armed || timer == '0) begin
        timer <= sample_interval - 16'd1;
        armed <= 1'b1;
      end else begin
        timer <= timer - 16'd1;
      end
    end
  end

  assign fire     = armed & (timer == '0) & (sample_interval != '0);
  assign trigger  = enable & (fire | sample_req);
  assign scanning = (state_q == ST_SCAN);
  assign last_idx = (idx == SEL_W'(NUM_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (trigger) state_d = ST_SCAN;
      ST_SCAN: if (last_idx) state_d = ST_DONE;
      ST_DONE: state_d = (enable && (pending || trigger)) ? ST_SCAN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      pending <= 1'b0;
      seq     <= '0;
    end else begin
      idx <= (scanning && !last_idx) ? idx + 1'b1 : '0;
      if (scanning) begin
        if (!enable)      pending <= 1'b0;
        else if (trigger) pending <= 1'b1;
      end else begin
        pending <= 1'b0;
      end
      if (state_q == ST_DONE) seq <= seq + 1'b1;
    end
  end

  assign bus.counter_select = scanning ? idx : '0;
  assign cur   = bus.selected_counter;
  assign delta = cur - prev[idx];
  assign busy  = scanning;

  // prev follows the bank even when the record is dropped, so later deltas stay exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) prev[i] <= '0;
    end else if (scanning) begin
      prev[idx] <= cur;
    end
  end

  assign drop = scanning & fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clear_stats)       drop_count <= DROP_W'(1);
      else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
    end else if (clear_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  perf_sample_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (scanning),
    .push_data (pack_rec(seq, idx, delta)),
    .pop       (bus.out_ready),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_seq   = head[REC_SEQ_LSB +: SEQ_W];
  assign bus.out_idx   = head[REC_IDX_LSB +: SEL_W];
  assign bus.out_delta = head[REC_DELTA_LSB +: DELTA_W];

endmodule

// File: tb/tb_perf_sample_engine.sv
// Randomized bench for perf_sample_engine against a scan-level queue model.
module tb_perf_sample_engine;
  import perf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample_interval = '0;
  logic        sample_req = 1'b0;
  logic        clear_stats = 1'b0;
  logic [4:0]  fifo_level;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_count;

  perf_sample_engine_if bus();

  perf_sample_engine dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .sample_interval (sample_interval),
    .sample_req      (sample_req),
    .clear_stats     (clear_stats),
    .bus             (bus),
    .fifo_level      (fifo_level),
    .busy            (busy),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  logic [31:0] bank [16];
  always_comb bus.selected_counter = bank[bus.counter_select];

  typedef struct packed {
    logic [7:0]  seq;
    logic [3:0]  idx;
    logic [31:0] delta;
  } rec_t;

  rec_t        mq[$];
  logic [31:0] mprev [NUM_CNT];
  logic [31:0] last_delta [NUM_CNT];
  int          mseq;
  int          mdrop;
  bit          movf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NUM_CNT; i++) mprev[i] = '0;
    mseq  = 0;
    mdrop = 0;
    movf  = 1'b0;
  endtask

  // One whole scan: every counter's delta against the last scan, FIFO capped at depth.
  task automatic model_scan();
    for (int i = 0; i < NUM_CNT; i++) begin
      rec_t r;
      r.seq   = 8'(mseq);
      r.idx   = 4'(i);
      r.delta = bank[i] - mprev[i];
      mprev[i] = bank[i];
      if (mq.size() < FIFO_DEPTH) mq.push_back(r);
      else begin
        movf = 1'b1;
        if (mdrop < 65535) mdrop++;
      end
    end
    mseq = (mseq + 1) % 256;
  endtask

  task automatic step();
    bit pop;
    pop = bus.out_valid & bus.out_ready;
    if (pop && bus.out_idx < NUM_CNT) last_delta[bus.out_idx] = bus.out_delta;
    @(posedge clk);
    #1;
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (bus.out_valid) begin
      if (mq.size() == 0) check("extra_record", 1, 0);
      else begin
        check("rec_seq", bus.out_seq, mq[0].seq);
        check("rec_idx", bus.out_idx, mq[0].idx);
        check("rec_delta", bus.out_delta, mq[0].delta);
      end
    end else begin
      check("empty_outputs", {bus.out_seq, bus.out_idx, bus.out_delta}, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, bus.counter_select, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_head"}, {bus.out_seq, bus.out_idx, bus.out_delta}, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_drops"}, drop_count, 0);
  endtask

  task automatic do_scan();
    int n;
    model_scan();
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      check("scan_select", bus.counter_select, n);
      n++;
      step();
    end
    check("busy_cycles", n, NUM_CNT);
    check("done_select", bus.counter_select, 0);
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || bus.out_valid) && n < 300) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus.out_ready = 1'b0;
    check("drain_in_time", n < 300, 1);
    check("drain_level", fifo_level, 0);
  endtask

  task automatic randomize_bank();
    for (int i = 0; i < NUM_CNT; i++) bank[i] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit pbusy;
    int starts[$];
    int exp_starts[4] = '{21, 41, 51, 61};

    for (int i = 0; i < 16; i++) bank[i] = '0;
    for (int i = 0; i < NUM_CNT; i++) last_delta[i] = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;

    // Raw values on the first scan
    for (int i = 0; i < NUM_CNT; i++) bank[i] = 100 + i;
    do_scan();
    check("t1_level", fifo_level, mq.size());
    drain();
    check("t1_irq_delta", last_delta[CNT_IRQ], 108);

    for (int i = 0; i < NUM_CNT; i++) bank[i] = 150 + i;
    do_scan();
    drain();
    check("t2_stall_delta", last_delta[CNT_STALL], 50);
    check("t2_cycle_delta", last_delta[CNT_CYCLE], 50);

    bank[CNT_CHIT] = 32'hFFFF_FFF0;
    do_scan();
    drain();
    bank[CNT_CHIT] = 32'h0000_0010;
    do_scan();
    drain();
    check("t3_wrap_delta", last_delta[CNT_CHIT], 32'h20);

    repeat (4) begin
      randomize_bank();
      do_scan();
      drain();
    end

    // Overfill with the consumer stalled
    randomize_bank();
    do_scan();
    randomize_bank();
    do_scan();
    check("t4_level", fifo_level, mq.size());
    check("t4_overflow", overflow, movf);
    check("t4_drops", drop_count, mdrop);
    check("t4_drops_abs", drop_count, 2);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    movf  = 1'b0;
    mdrop = 0;
    check("t4_clr_overflow", overflow, movf);
    check("t4_clr_drops", drop_count, mdrop);
    drain();

    // Interval timer with a coalesced mid-scan request
    enable = 1'b0;
    step();
    sample_interval = 16'd20;
    enable = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0;
    pbusy = 1'b0;
    while (cyc < 76) begin
      if (cyc == 10 || cyc == 35 || cyc == 60) randomize_bank();
      if (cyc == 20 || cyc == 40 || cyc == 50 || cyc == 60) model_scan();
      sample_req = (cyc == 44 || cyc == 46);
      step();
      cyc++;
      if (busy && !pbusy) starts.push_back(cyc);
      pbusy = busy;
    end
    sample_req = 1'b0;
    sample_interval = '0;
    check("t5_scan_count", starts.size(), 4);
    for (int i = 0; i < 4; i++)
      check("t5_scan_start", (i < starts.size()) ? starts[i] : -1, exp_starts[i]);
    drain();

    // Reset mid-scan at idx 4
    randomize_bank();
    model_scan();
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    cyc = 0;
    while (bus.counter_select != 4 && cyc < 20) begin
      step();
      cyc++;
    end
    check("t6_reached_idx4", bus.counter_select, 4);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    randomize_bank();
    do_scan();
    drain();
    check("t6_raw_delta", last_delta[CNT_IRQ], bank[CNT_IRQ]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
